nv_ram_rwsp_prm: RTL and testbench

- Parametrised successor of the fixed-geometry rwsp RAM models: one read port and one write port, both synchronous, with registered read address and an output register gated by ore.
- Adds per-granule write mask, selectable same-address collision policy, optional post-reset zero-clear engine, output valid tracking and a collision counter.
- Used as the FPGA model for NVDLA CBUF/CDMA/SDP buffers of arbitrary width/depth.

---
 rtl/nv_ram_prm_pkg.sv | 24 ++
 rtl/nv_ram_rwsp_prm_if.sv | 23 ++
 rtl/nv_ram_prm_clr.sv | 67 ++++++
 rtl/nv_ram_rwsp_prm.sv | 101 ++++++++++
 tb/tb_nv_ram_rwsp_prm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/nv_ram_prm_pkg.sv
// Shared types and helpers for the parametrised rwsp RAM model.
// Holds the init FSM states, the mask-width helper and the masked-merge helper.
package nv_ram_prm_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RDY = 1'b1
  } state_e;

  // Widest word the merge helper handles; instances must keep DW at or below this.
  localparam int MAX_W = 4096;

  function automatic int mw(input int dw, input int mg);
    return dw / mg;
  endfunction

  // bits is the mask already expanded to one bit per data bit.
  function automatic logic [MAX_W-1:0] merge_bits(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] bits);
    return (old_w & ~bits) | (new_w & bits);
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_prm_if.sv
// Read/write port bundle of the parametrised rwsp RAM.
// The master drives addresses, enables and write data; the slave returns read data.
interface nv_ram_rwsp_prm_if
  import nv_ram_prm_pkg::*;
#(
  parameter int DW = 257,
  parameter int AW = 8,
  parameter int MG = 1,
  parameter int MW = mw(DW, MG)
);
  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa;
  logic          we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;

  modport master (output ra, re, ore, wa, we, wmask, di, input dout, dout_vld);
  modport slave  (input ra, re, ore, wa, we, wmask, di, output dout, dout_vld);
endinterface

// File: rtl/nv_ram_prm_clr.sv
// Post-reset zero-clear engine: walks every address once, then hands the
// array write port over to the external write port.
module nv_ram_prm_clr
  import nv_ram_prm_pkg::*;
#(
  parameter int DW         = 257,
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int MW         = 257,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] di,
  input  logic [MW-1:0] wmask,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [MW-1:0] wr_mask,
  output logic          rdy,
  output logic          init_done
);
  localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam state_e        RST_ST  = (INIT_CLEAR != 0) ? CLR : RDY;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_ST;
      clr_addr_q <= '0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      init_done  <= (state_d == RDY);
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = wa;
    wr_data    = di;
    wr_mask    = wmask;
    case (state_q)
      CLR: begin
        // Port writes are dropped while the clear owns the array.
        wr_en   = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = '0;
        wr_mask = '1;
        if (clr_addr_q == LAST) state_d = RDY;
        else                    clr_addr_d = clr_addr_q + AW'(1);
      end
      default: wr_en = we && ({1'b0, wa} < DEPTH_A);
    endcase
  end

  assign rdy = (state_q == RDY);

endmodule

// File: rtl/nv_ram_rwsp_prm.sv
// Parametrised one-read/one-write synchronous RAM model with masked writes,
// registered read address, ore-gated output register and collision tracking.
module nv_ram_rwsp_prm
  import nv_ram_prm_pkg::*;
#(
  parameter int DW          = 257,
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int MG          = 1,
  parameter int COLLIDE_NEW = 0,
  parameter int INIT_CLEAR  = 1,
  parameter int CW          = 16
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  nv_ram_rwsp_prm_if.slave    bus,
  output logic                init_done,
  output logic [CW-1:0]       collide_cnt,
  input  logic [31:0]         pwrbus_ram_pd
);
  localparam int          MW      = mw(DW, MG);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          rdy;
  logic [DW-1:0] wr_bits, di_bits, wr_word, rd_old, rd_new;
  logic [AW-1:0] ra_d;
  logic          re_d;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;
  logic          collide;
  logic          unused_pwr;
  logic [DW-1:0] mem [DEPTH];

  assign unused_pwr = ^pwrbus_ram_pd;

  nv_ram_prm_clr #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .MW(MW), .INIT_CLEAR(INIT_CLEAR)
  ) u_clr (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .we        (bus.we),
    .wa        (bus.wa),
    .di        (bus.di),
    .wmask     (bus.wmask),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rdy       (rdy),
    .init_done (init_done)
  );

  always_comb begin
    wr_bits = '0;
    di_bits = '0;
    for (int g = 0; g < MW; g++) begin
      wr_bits[g*MG +: MG] = {MG{wr_mask[g]}};
      di_bits[g*MG +: MG] = {MG{bus.wmask[g]}};
    end
  end

  assign wr_word = DW'(merge_bits(MAX_W'(mem[wr_addr]), MAX_W'(wr_data), MAX_W'(wr_bits)));

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Read stage: array is read through the registered address ra_d.
  assign rd_old  = ({1'b0, ra_d} < DEPTH_A) ? mem[ra_d] : '0;
  assign collide = rdy & bus.ore & bus.we & (bus.wa == ra_d);
  // Under the new-data policy the output sees the word as it will be after this edge.
  assign rd_new  = ((COLLIDE_NEW != 0) && collide && wr_en)
                 ? DW'(merge_bits(MAX_W'(rd_old), MAX_W'(bus.di), MAX_W'(di_bits)))
                 : rd_old;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ra_d        <= '0;
      re_d        <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      collide_cnt <= '0;
    end else if (rdy) begin
      if (bus.re) ra_d <= bus.ra;
      re_d <= bus.re;
      if (bus.ore) begin
        dout_q     <= rd_new;
        dout_vld_q <= re_d;
      end
      if (collide && (collide_cnt != '1)) collide_cnt <= collide_cnt + CW'(1);
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;

endmodule

// File: tb/tb_nv_ram_rwsp_prm.sv
// Bench for nv_ram_rwsp_prm: two instances (old-data and new-data collision
// policy) share one stimulus stream and are checked against a word-level model.
module tb_nv_ram_rwsp_prm;
  import nv_ram_prm_pkg::*;

  localparam int DW = 32, DEPTH = 200, AW = 8, MG = 8, MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic init_a, init_b;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [31:0] pwr = 32'h0;

  always #5 clk = ~clk;

  nv_ram_rwsp_prm_if #(.DW(DW), .AW(AW), .MG(MG)) if_a ();
  nv_ram_rwsp_prm_if #(.DW(DW), .AW(AW), .MG(MG)) if_b ();

  assign if_b.ra    = if_a.ra;
  assign if_b.re    = if_a.re;
  assign if_b.ore   = if_a.ore;
  assign if_b.wa    = if_a.wa;
  assign if_b.we    = if_a.we;
  assign if_b.wmask = if_a.wmask;
  assign if_b.di    = if_a.di;

  nv_ram_rwsp_prm #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MG(MG), .COLLIDE_NEW(0),
                    .INIT_CLEAR(1), .CW(2)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .bus(if_a),
    .init_done(init_a), .collide_cnt(cnt_a), .pwrbus_ram_pd(pwr));

  nv_ram_rwsp_prm #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MG(MG), .COLLIDE_NEW(1),
                    .INIT_CLEAR(1), .CW(16)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .bus(if_b),
    .init_done(init_b), .collide_cnt(cnt_b), .pwrbus_ram_pd(pwr));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: word array plus the observable read-side state.
  logic [31:0] m_mem [DEPTH];
  bit          m_rdy;
  int          m_clr, m_rad, m_cnt_a, m_cnt_b;
  bit          m_red, m_vld;
  logic [31:0] m_dout_a, m_dout_b;

  typedef struct {
    bit          we;
    logic [7:0]  wa;
    logic [3:0]  mask;
    logic [31:0] di;
    bit          re;
    logic [7:0]  ra;
    bit          ore;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          ev;
    int          eca;
    int          ecb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old_w, input logic [31:0] new_w,
                                      input logic [3:0] mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_rdy = 0; m_clr = 0; m_rad = 0; m_red = 0; m_vld = 0;
    m_dout_a = '0; m_dout_b = '0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_edge();
    logic [31:0] old_w, new_w;
    bit coll;
    if (!m_rdy) begin
      m_mem[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_rdy = 1;
    end else begin
      old_w = (m_rad < DEPTH) ? m_mem[m_rad] : 32'h0;
      coll  = if_a.ore && if_a.we && (int'(if_a.wa) == m_rad);
      if (if_a.we && int'(if_a.wa) < DEPTH)
        m_mem[if_a.wa] = mrg(m_mem[if_a.wa], if_a.di, if_a.wmask);
      new_w = (m_rad < DEPTH) ? m_mem[m_rad] : 32'h0;
      if (if_a.ore) begin
        m_dout_a = old_w;
        m_dout_b = new_w;
        m_vld    = m_red;
      end
      if (coll) begin
        if (m_cnt_a < 3) m_cnt_a++;
        if (m_cnt_b < 65535) m_cnt_b++;
      end
      if (if_a.re) m_rad = int'(if_a.ra);
      m_red = if_a.re;
    end
  endtask

  task automatic check_model();
    chk("dout_old", if_a.dout, m_dout_a);
    chk("dout_new", if_b.dout, m_dout_b);
    chk("vld_old", 32'(if_a.dout_vld), 32'(m_vld));
    chk("vld_new", 32'(if_b.dout_vld), 32'(m_vld));
    chk("init_old", 32'(init_a), 32'(m_rdy));
    chk("init_new", 32'(init_b), 32'(m_rdy));
    chk("cnt_old", 32'(cnt_a), 32'(m_cnt_a));
    chk("cnt_new", 32'(cnt_b), 32'(m_cnt_b));
  endtask

  task automatic drive(input bit we, input logic [7:0] wa, input logic [3:0] mask,
                       input logic [31:0] di, input bit re, input logic [7:0] ra,
                       input bit ore);
    if_a.we = we; if_a.wa = wa; if_a.wmask = mask; if_a.di = di;
    if_a.re = re; if_a.ra = ra; if_a.ore = ore;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int cycles;
    logic [7:0] wa_r, ra_r;

    tbl[0]  = '{1'b1, 8'd5,   4'hF, 32'hAABBCCDD, 1'b0, 8'd0,   1'b0, 32'h0, 32'h0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 8'd5,   4'h5, 32'h11223344, 1'b0, 8'd0,   1'b0, 32'h0, 32'h0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   1'b0, 32'h0, 32'h0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b1, 0, 0};
    tbl[4]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd9,   1'b0, 32'hAA22CC44, 32'hAA22CC44, 1'b1, 0, 0};
    tbl[5]  = '{1'b1, 8'd9,   4'hF, 32'h000000FF, 1'b0, 8'd0,   1'b1, 32'h0, 32'h000000FF, 1'b1, 1, 1};
    tbl[6]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b1, 32'h000000FF, 32'h000000FF, 1'b0, 1, 1};
    tbl[7]  = '{1'b1, 8'd100, 4'hF, 32'h12345678, 1'b1, 8'd100, 1'b0, 32'h000000FF, 32'h000000FF, 1'b0, 1, 1};
    tbl[8]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b1, 32'h12345678, 32'h12345678, 1'b1, 1, 1};
    tbl[9]  = '{1'b1, 8'd210, 4'hF, 32'hDEADBEEF, 1'b1, 8'd210, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 1, 1};
    tbl[10] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b1, 32'h0, 32'h0, 1'b1, 1, 1};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    // Clear aborted at cycle 100, with port traffic that must be ignored.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'd7, 4'hF, 32'hFFFFFFFF, 1'b1, 8'd7, 1'b1);
      step();
    end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_model();
    rst_n = 1'b1;

    cycles = 0;
    while (!init_a && cycles < 300) begin
      if (cycles < 50) drive(1'b1, 8'd7, 4'hF, 32'hFFFFFFFF, 1'b1, 8'd3, 1'b1);
      else             drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0, 1'b0);
      step();
      cycles++;
    end
    chk("init_latency", 32'(cycles), 32'd200);

    // Read every address back after the clear.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'(a), 1'b1);
      step();
      if (a == 8) begin
        chk("clr_wins_addr7", if_a.dout, 32'h0);
        chk("clr_wins_vld", 32'(if_a.dout_vld), 32'd1);
      end
    end
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0, 1'b1);
    step();
    chk("sweep_last_vld", 32'(if_a.dout_vld), 32'd1);
    step();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].mask, tbl[i].di, tbl[i].re, tbl[i].ra, tbl[i].ore);
      step();
      chk($sformatf("tbl%0d_dout_old", i), if_a.dout, tbl[i].ea);
      chk($sformatf("tbl%0d_dout_new", i), if_b.dout, tbl[i].eb);
      chk($sformatf("tbl%0d_vld", i), 32'(if_a.dout_vld), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_cnt_old", i), 32'(cnt_a), 32'(tbl[i].eca));
      chk($sformatf("tbl%0d_cnt_new", i), 32'(cnt_b), 32'(tbl[i].ecb));
    end

    // Four more collisions on addr 3: the 2-bit counter saturates.
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'd3, 4'hF, 32'(k + 1), 1'b0, 8'd0, 1'b1);
      step();
    end
    chk("sat_cnt_old", 32'(cnt_a), 32'd3);
    chk("sat_cnt_new", 32'(cnt_b), 32'd5);
    chk("sat_dout_old", if_a.dout, 32'd3);
    chk("sat_dout_new", if_b.dout, 32'd4);

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      wa_r = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(195, 215));
      ra_r = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(195, 215));
      drive(1'($urandom % 2), wa_r, 4'($urandom), $urandom, 1'($urandom % 2), ra_r,
            1'($urandom % 2));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
